// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
// Shares one single-port RAM between an SPI slave and a local host port.
// SPI words are decoded into address loads and queued RAM accesses; the
// queued SPI access and host requests are arbitrated round-robin, and read
// data is routed back to whichever side issued the read.

module spi_ram_arbiter #(
   parameter int ADDR_SIZE = 8,
   parameter int DATA_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   // SPI slave side
   input  logic [9:0]           spi_rx_data,
   input  logic                 spi_rx_valid,
   output logic [7:0]           spi_tx_data,
   output logic                 spi_tx_valid,
   output logic                 spi_ovf,
   // local host side
   input  logic                 host_req,
   input  logic                 host_we,
   input  logic [ADDR_SIZE-1:0] host_addr,
   input  logic [DATA_SIZE-1:0] host_wdata,
   output logic                 host_gnt,
   output logic                 host_rvalid,
   output logic [DATA_SIZE-1:0] host_rdata,
   // RAM side
   output logic                 ram_en,
   output logic                 ram_we,
   output logic [ADDR_SIZE-1:0] ram_addr,
   output logic [DATA_SIZE-1:0] ram_din,
   input  logic [DATA_SIZE-1:0] ram_dout
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SPI_ACC  = 2'd1,
      ST_HOST_ACC = 2'd2,
      ST_RD_WAIT  = 2'd3
   } state_t;

   typedef enum logic {
      GRANT_SPI  = 1'b0,
      GRANT_HOST = 1'b1
   } grant_t;

   // SPI command encodings in spi_rx_data[9:8]
   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;

   state_t                 state_r;
   grant_t                 last_grant_r;
   grant_t                 cur_src_r;
   logic                   cur_rd_r;

   logic                   rx_valid_prev_r;
   logic [ADDR_SIZE-1:0]   wr_addr_r;
   logic [ADDR_SIZE-1:0]   rd_addr_r;
   logic                   spi_pend_r;
   logic                   spi_op_rd_r;
   logic [DATA_SIZE-1:0]   spi_wdata_r;

   logic                   rise_s;
   logic                   fall_s;
   logic [1:0]             cmd_s;
   logic [7:0]             payload_s;
   logic                   is_access_s;
   logic                   pend_clear_s;
   logic                   accept_s;
   logic                   ovf_s;
   logic                   grant_spi_s;
   logic                   grant_host_s;
   logic [ADDR_SIZE-1:0]   spi_addr_s;
   logic [DATA_SIZE-1:0]   spi_din_s;

   // Edge detection on spi_rx_valid and SPI command/overrun decode
   always_comb begin
      rise_s       = spi_rx_valid & ~rx_valid_prev_r;
      fall_s       = ~spi_rx_valid & rx_valid_prev_r;
      cmd_s        = spi_rx_data[9:8];
      payload_s    = spi_rx_data[7:0];
      // 01 (write) and 11 (read) both carry bit 8 set and need a RAM access
      is_access_s  = cmd_s[0];
      // the pending slot frees at the end of SPI_ACC, so a capture landing on
      // that same edge reuses it instead of overrunning
      pend_clear_s = (state_r == ST_SPI_ACC);
      if (rise_s && is_access_s) begin
         accept_s = ~spi_pend_r | pend_clear_s;
         ovf_s    = spi_pend_r & ~pend_clear_s;
      end else begin
         accept_s = 1'b0;
         ovf_s    = 1'b0;
      end
   end

   // RAM command for the queued SPI access
   always_comb begin
      if (spi_op_rd_r) begin
         spi_addr_s = rd_addr_r;
         spi_din_s  = {DATA_SIZE{1'b0}};
      end else begin
         spi_addr_s = wr_addr_r;
         spi_din_s  = spi_wdata_r;
      end
   end

   // Round-robin arbitration, only evaluated while IDLE
   always_comb begin
      grant_spi_s  = 1'b0;
      grant_host_s = 1'b0;
      if (state_r == ST_IDLE) begin
         if (spi_pend_r && host_req) begin
            // tie: the side that did not win last time goes first
            if (last_grant_r == GRANT_HOST) begin
               grant_spi_s = 1'b1;
            end else begin
               grant_host_s = 1'b1;
            end
         end else if (spi_pend_r) begin
            grant_spi_s = 1'b1;
         end else if (host_req) begin
            grant_host_s = 1'b1;
         end else begin
            grant_spi_s  = 1'b0;
            grant_host_s = 1'b0;
         end
      end else begin
         grant_spi_s  = 1'b0;
         grant_host_s = 1'b0;
      end
   end

   // SPI address registers and previous spi_rx_valid for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_valid_prev_r <= 1'b0;
         wr_addr_r       <= {ADDR_SIZE{1'b0}};
         rd_addr_r       <= {ADDR_SIZE{1'b0}};
      end else begin
         rx_valid_prev_r <= spi_rx_valid;
         if (rise_s && (cmd_s == CMD_WR_ADDR)) begin
            wr_addr_r <= ADDR_SIZE'(payload_s);
         end else begin
            wr_addr_r <= wr_addr_r;
         end
         if (rise_s && (cmd_s == CMD_RD_ADDR)) begin
            rd_addr_r <= ADDR_SIZE'(payload_s);
         end else begin
            rd_addr_r <= rd_addr_r;
         end
      end
   end

   // Access FSM: SPI pending slot, RAM sequencing and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         last_grant_r <= GRANT_HOST;
         cur_src_r    <= GRANT_HOST;
         cur_rd_r     <= 1'b0;
         spi_pend_r   <= 1'b0;
         spi_op_rd_r  <= 1'b0;
         spi_wdata_r  <= {DATA_SIZE{1'b0}};
         spi_tx_data  <= 8'h00;
         spi_tx_valid <= 1'b0;
         spi_ovf      <= 1'b0;
         host_gnt     <= 1'b0;
         host_rvalid  <= 1'b0;
         host_rdata   <= {DATA_SIZE{1'b0}};
         ram_en       <= 1'b0;
         ram_we       <= 1'b0;
         ram_addr     <= {ADDR_SIZE{1'b0}};
         ram_din      <= {DATA_SIZE{1'b0}};
      end else begin
         spi_ovf <= ovf_s;

         // a new capture wins over the end-of-access clear on the same edge
         if (accept_s) begin
            spi_pend_r  <= 1'b1;
            spi_op_rd_r <= cmd_s[1];
            spi_wdata_r <= DATA_SIZE'(payload_s);
         end else if (pend_clear_s) begin
            spi_pend_r <= 1'b0;
         end else begin
            spi_pend_r <= spi_pend_r;
         end

         // read data to SPI is held until the master starts a new word or ends the frame
         if ((state_r == ST_RD_WAIT) && (cur_src_r == GRANT_SPI)) begin
            spi_tx_valid <= 1'b1;
         end else if (rise_s || fall_s) begin
            spi_tx_valid <= 1'b0;
         end else begin
            spi_tx_valid <= spi_tx_valid;
         end

         case (state_r)
            ST_IDLE: begin
               host_gnt    <= 1'b0;
               host_rvalid <= 1'b0;
               if (grant_spi_s) begin
                  state_r      <= ST_SPI_ACC;
                  last_grant_r <= GRANT_SPI;
                  cur_src_r    <= GRANT_SPI;
                  cur_rd_r     <= spi_op_rd_r;
                  ram_en       <= 1'b1;
                  ram_we       <= ~spi_op_rd_r;
                  ram_addr     <= spi_addr_s;
                  ram_din      <= spi_din_s;
               end else if (grant_host_s) begin
                  state_r      <= ST_HOST_ACC;
                  last_grant_r <= GRANT_HOST;
                  cur_src_r    <= GRANT_HOST;
                  cur_rd_r     <= ~host_we;
                  host_gnt     <= 1'b1;
                  ram_en       <= 1'b1;
                  ram_we       <= host_we;
                  ram_addr     <= host_addr;
                  ram_din      <= host_we ? host_wdata : {DATA_SIZE{1'b0}};
               end else begin
                  state_r <= ST_IDLE;
                  ram_en  <= 1'b0;
                  ram_we  <= 1'b0;
               end
            end
            ST_SPI_ACC, ST_HOST_ACC: begin
               // the strobe lasts exactly one cycle; address/data stay put
               ram_en      <= 1'b0;
               ram_we      <= 1'b0;
               host_gnt    <= 1'b0;
               host_rvalid <= 1'b0;
               state_r     <= cur_rd_r ? ST_RD_WAIT : ST_IDLE;
            end
            ST_RD_WAIT: begin
               ram_en   <= 1'b0;
               ram_we   <= 1'b0;
               host_gnt <= 1'b0;
               if (cur_src_r == GRANT_HOST) begin
                  host_rdata  <= ram_dout;
                  host_rvalid <= 1'b1;
               end else begin
                  spi_tx_data <= 8'(ram_dout);
                  host_rvalid <= 1'b0;
               end
               state_r <= ST_IDLE;
            end
            default: begin
               state_r     <= ST_IDLE;
               ram_en      <= 1'b0;
               ram_we      <= 1'b0;
               host_gnt    <= 1'b0;
               host_rvalid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: stimulus pushes expected RAM strobes
// and read results into queues; a negedge monitor pops and compares them.

module tb_spi_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] spi_rx_data;
   logic       spi_rx_valid;
   logic [7:0] spi_tx_data;
   logic       spi_tx_valid;
   logic       spi_ovf;
   logic       host_req;
   logic       host_we;
   logic [7:0] host_addr;
   logic [7:0] host_wdata;
   logic       host_gnt;
   logic       host_rvalid;
   logic [7:0] host_rdata;
   logic       ram_en;
   logic       ram_we;
   logic [7:0] ram_addr;
   logic [7:0] ram_din;
   logic [7:0] ram_dout = 8'h00;

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] din;
   } ram_exp_t;

   ram_exp_t   ram_q[$];
   logic [7:0] spi_q[$];
   logic [7:0] host_q[$];

   int n_vec  = 0;
   int n_miss = 0;
   int ovf_cnt = 0;
   int gnt_cnt = 0;
   logic prev_txv = 1'b0;

   logic [7:0] mem [0:255];
   logic       mem_init_done = 1'b0;

   spi_ram_arbiter #(.ADDR_SIZE(8), .DATA_SIZE(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .spi_rx_data  (spi_rx_data),
      .spi_rx_valid (spi_rx_valid),
      .spi_tx_data  (spi_tx_data),
      .spi_tx_valid (spi_tx_valid),
      .spi_ovf      (spi_ovf),
      .host_req     (host_req),
      .host_we      (host_we),
      .host_addr    (host_addr),
      .host_wdata   (host_wdata),
      .host_gnt     (host_gnt),
      .host_rvalid  (host_rvalid),
      .host_rdata   (host_rdata),
      .ram_en       (ram_en),
      .ram_we       (ram_we),
      .ram_addr     (ram_addr),
      .ram_din      (ram_din),
      .ram_dout     (ram_dout)
   );

   always #5 clk = ~clk;

   // synchronous single-port RAM model, RAM[3C] preloaded with 55
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         mem[8'h3C]    <= 8'h55;
         mem_init_done <= 1'b1;
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_din;
         else        ram_dout      <= mem[ram_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      n_vec++;
      n_miss++;
      $display("FAIL %s: unexpected event (t=%0t)", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_host_gnt(input string name);
      int k;
      k = 0;
      while (host_gnt !== 1'b1 && k < 10) begin
         tick();
         k++;
      end
      check(name, host_gnt, 1);
      host_req = 1'b0;
   endtask

   task automatic push_ram(input logic we, input logic [7:0] a, input logic [7:0] d);
      ram_exp_t e;
      e.we = we; e.addr = a; e.din = d;
      ram_q.push_back(e);
   endtask

   // monitor: pops expectations whenever the DUT presents an output
   always @(negedge clk) begin
      ram_exp_t e;
      if (!rst) begin
         if (ram_en) begin
            if (ram_q.size() == 0) flag("ram_strobe");
            else begin
               e = ram_q.pop_front();
               check("ram_we", ram_we, e.we);
               check("ram_addr", ram_addr, e.addr);
               if (e.we) check("ram_din", ram_din, e.din);
            end
         end
         if (spi_tx_valid && !prev_txv) begin
            if (spi_q.size() == 0) flag("spi_tx_valid");
            else check("spi_tx_data", spi_tx_data, spi_q.pop_front());
         end
         if (host_rvalid) begin
            if (host_q.size() == 0) flag("host_rvalid");
            else check("host_rdata", host_rdata, host_q.pop_front());
         end
         if (spi_ovf) ovf_cnt++;
         if (host_gnt) gnt_cnt++;
      end
      prev_txv <= spi_tx_valid;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; spi_rx_data = 10'h000; spi_rx_valid = 1'b0;
      host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
      tick(); tick();
      check("reset_ctrl", {spi_tx_valid, spi_ovf, host_gnt, host_rvalid, ram_en, ram_we}, 0);
      check("reset_data", {spi_tx_data, host_rdata, ram_addr, ram_din}, 0);
      rst = 1'b0;
      tick();

      // 1: SPI write address 05, write A7
      spi_rx_data = 10'h005; spi_rx_valid = 1'b1; tick();
      spi_rx_valid = 1'b0; tick();
      spi_rx_data = 10'h1A7; spi_rx_valid = 1'b1;
      push_ram(1'b1, 8'h05, 8'hA7);
      tick();
      check("t1_cycle0_en", ram_en, 0);
      tick();
      check("t1_strobe", {ram_en, ram_we, ram_addr, ram_din, host_gnt}, {1'b1, 1'b1, 8'h05, 8'hA7, 1'b0});
      tick();
      check("t1_cycle2_en", ram_en, 0);
      spi_rx_valid = 1'b0; tick();
      check("t1_no_gnt", gnt_cnt, 0);

      // 2: SPI read address 05, read -> A7 three edges after capture, held
      spi_rx_data = 10'h205; spi_rx_valid = 1'b1; tick();
      spi_rx_valid = 1'b0; tick();
      spi_rx_data = 10'h300; spi_rx_valid = 1'b1;
      push_ram(1'b0, 8'h05, 8'h00);
      spi_q.push_back(8'hA7);
      tick();
      tick();
      check("t2_strobe", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 8'h05});
      tick();
      check("t2_early_valid", spi_tx_valid, 0);
      tick();
      check("t2_tx", {spi_tx_valid, spi_tx_data}, {1'b1, 8'hA7});
      tick(); tick();
      check("t2_tx_held", spi_tx_valid, 1);
      spi_rx_valid = 1'b0; tick();
      check("t2_tx_cleared", spi_tx_valid, 0);

      // 3: host read 3C -> 55, gnt in cycle 1, rvalid in cycle 3
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h3C;
      push_ram(1'b0, 8'h3C, 8'h00);
      host_q.push_back(8'h55);
      tick();
      check("t3_gnt", host_gnt, 1);
      host_req = 1'b0; tick();
      check("t3_cycle2", {host_gnt, host_rvalid}, 0);
      tick();
      check("t3_rvalid", {host_rvalid, host_rdata}, {1'b1, 8'h55});
      tick();

      // 4: collisions after reset: SPI first, then host, then host before SPI
      rst = 1'b1; tick(); rst = 1'b0; tick();
      spi_rx_data = 10'h010; spi_rx_valid = 1'b1; tick();
      spi_rx_valid = 1'b0; tick();
      spi_rx_data = 10'h1B1; spi_rx_valid = 1'b1;
      push_ram(1'b1, 8'h10, 8'hB1);
      push_ram(1'b1, 8'h20, 8'hC3);
      push_ram(1'b1, 8'h10, 8'hB2);
      tick();
      spi_rx_valid = 1'b0;
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'hC3;
      tick();
      check("t4_spi_first", {ram_en, ram_addr, host_gnt}, {1'b1, 8'h10, 1'b0});
      spi_rx_data = 10'h1B2; spi_rx_valid = 1'b1;
      tick();
      check("t4_no_ovf", spi_ovf, 0);
      tick();
      check("t4_host_second", {host_gnt, ram_addr}, {1'b1, 8'h20});
      host_req = 1'b0; spi_rx_valid = 1'b0;
      tick(); tick();
      check("t4_spi_third", {ram_en, ram_addr, ram_din}, {1'b1, 8'h10, 8'hB2});
      tick(); tick();

      // 5: second SPI write while the first is stalled behind host traffic
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h3C;
      spi_rx_data = 10'h1D1; spi_rx_valid = 1'b1;
      push_ram(1'b0, 8'h3C, 8'h00);
      host_q.push_back(8'h55);
      tick();
      check("t5_host_gnt", host_gnt, 1);
      host_we = 1'b1; host_addr = 8'h31; host_wdata = 8'h12;
      spi_rx_valid = 1'b0;
      tick();
      spi_rx_data = 10'h1D2; spi_rx_valid = 1'b1;
      tick();
      check("t5_ovf", spi_ovf, 1);
      push_ram(1'b1, 8'h10, 8'hD1);
      push_ram(1'b1, 8'h31, 8'h12);
      tick();
      check("t5_ovf_pulse", spi_ovf, 0);
      wait_host_gnt("t5_host2_gnt");
      spi_rx_valid = 1'b0;
      tick(); tick();

      // 6: reset during RD_WAIT, then the first tie goes to SPI
      spi_rx_data = 10'h231; spi_rx_valid = 1'b1; tick();
      spi_rx_valid = 1'b0; tick();
      spi_rx_data = 10'h300; spi_rx_valid = 1'b1;
      push_ram(1'b0, 8'h31, 8'h00);
      spi_q.push_back(8'h12);
      tick(); tick(); tick(); tick();
      check("t6_spi_rd", {spi_tx_valid, spi_tx_data}, {1'b1, 8'h12});
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h3C;
      push_ram(1'b0, 8'h3C, 8'h00);
      tick();
      check("t6_host_gnt", host_gnt, 1);
      host_req = 1'b0;
      tick();
      #1;
      rst = 1'b1; spi_rx_valid = 1'b0;
      #1;
      check("t6_async_reset", {ram_en, host_rvalid, spi_tx_valid, host_gnt}, 0);
      tick();
      rst = 1'b0;
      tick();
      spi_rx_data = 10'h1E1; spi_rx_valid = 1'b1;
      push_ram(1'b1, 8'h00, 8'hE1);
      push_ram(1'b1, 8'h22, 8'hC5);
      tick();
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'h22; host_wdata = 8'hC5;
      tick();
      check("t6_tie_spi", {ram_en, ram_addr, ram_din, host_gnt}, {1'b1, 8'h00, 8'hE1, 1'b0});
      wait_host_gnt("t6_host_gnt2");
      spi_rx_valid = 1'b0;
      repeat (6) tick();

      check("ram_q_drained", ram_q.size(), 0);
      check("spi_q_drained", spi_q.size(), 0);
      check("host_q_drained", host_q.size(), 0);
      check("ovf_count", ovf_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
